// File: rtl/aes_result_checker.sv
// -----------------------------------------------------------------------------
// aes_result_checker
//
// Consumes plaintext/ciphertext blocks from the data generator's data FIFO,
// presents each block to the AES chip under test, captures the chip's answer,
// pops the matching golden block from the generator's result FIFO and compares
// the two. Keeps saturating pass / fail / timeout statistics plus a sticky
// error flag and the first mismatching (got, expected) pair.
//
// Parameters
//   TIMEOUT      maximum cycles to wait for dut_done after dut_start
//   CNT_W        width of each statistics counter
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   work           in   enable; a new transaction starts only while high
//   clear          in   synchronous clear of counters, error and capture
//   data_empty     in   data FIFO empty
//   data_require   out  data FIFO pop strobe (one cycle)
//   data           in   data FIFO output, valid the cycle after the pop
//   result_empty   in   golden result FIFO empty
//   result_require out  result FIFO pop strobe (one cycle)
//   result         in   result FIFO output, valid the cycle after the pop
//   dut_din        out  block presented to the chip, held until next load
//   dut_start      out  one-cycle start pulse to the chip
//   dut_dout       in   chip output, valid while dut_done is high
//   dut_done       in   chip completion pulse
//   busy           out  FSM is not idle
//   pass_cnt       out  matching blocks
//   fail_cnt       out  mismatches plus timeouts
//   timeout_cnt    out  timeouts
//   error          out  sticky, set on the first fail
//   fail_got       out  chip output of the first fail (0 for a timeout)
//   fail_exp       out  golden value of the first fail
// -----------------------------------------------------------------------------
module aes_result_checker #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             work,
    input  logic             clear,
    input  logic             data_empty,
    output logic             data_require,
    input  logic [127:0]     data,
    input  logic             result_empty,
    output logic             result_require,
    input  logic [127:0]     result,
    output logic [127:0]     dut_din,
    output logic             dut_start,
    input  logic [127:0]     dut_dout,
    input  logic             dut_done,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             error,
    output logic [127:0]     fail_got,
    output logic [127:0]     fail_exp
);

    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DRIVE    = 3'd2,
        S_WAIT     = 3'd3,
        S_EXPECT   = 3'd4,
        S_LOAD_EXP = 3'd5,
        S_CMP      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       din_q, din_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               to_q, to_d;
    logic [127:0]       got_q, got_d;
    logic [127:0]       exp_q, exp_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic [CNT_W-1:0]   tocnt_q, tocnt_d;
    logic               error_q, error_d;
    logic [127:0]       fail_got_q, fail_got_d;
    logic [127:0]       fail_exp_q, fail_exp_d;

    logic               cmp_pass;
    logic               cmp_fail;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            din_q      <= '0;
            timer_q    <= '0;
            to_q       <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            tocnt_q    <= '0;
            error_q    <= 1'b0;
            fail_got_q <= '0;
            fail_exp_q <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            timer_q    <= timer_d;
            to_q       <= to_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tocnt_q    <= tocnt_d;
            error_q    <= error_d;
            fail_got_q <= fail_got_d;
            fail_exp_q <= fail_exp_d;
        end
    end

    // Compare operands are always written before they are read within a
    // transaction, so they need no reset.
    always_ff @(posedge clk) begin
        got_q <= got_d;
        exp_q <= exp_d;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (work && !data_empty) state_d = S_FETCH;
            S_FETCH:    state_d = S_DRIVE;
            S_DRIVE:    state_d = S_WAIT;
            S_WAIT:     if (dut_done || (timer_q == TMR_MAX)) state_d = S_EXPECT;
            // A golden entry is consumed even after a timeout so the data
            // and result FIFOs stay aligned.
            S_EXPECT:   if (!result_empty) state_d = S_LOAD_EXP;
            S_LOAD_EXP: state_d = S_CMP;
            S_CMP:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        data_require   = 1'b0;
        result_require = 1'b0;
        dut_start      = 1'b0;
        busy           = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   data_require   = work && !data_empty;
            S_DRIVE:  dut_start      = 1'b1;
            S_EXPECT: result_require = !result_empty;
            default:  ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and statistics
    // -------------------------------------------------------------------------
    always_comb begin
        din_d   = din_q;
        timer_d = timer_q;
        to_d    = to_q;
        got_d   = got_q;
        exp_d   = exp_q;

        if (state_q == S_FETCH) begin
            din_d = data;
        end

        if (state_q == S_DRIVE) begin
            timer_d = '0;
            to_d    = 1'b0;
        end

        // dut_done outside WAIT is deliberately ignored.
        if (state_q == S_WAIT) begin
            if (dut_done) begin
                got_d = dut_dout;
            end else if (timer_q == TMR_MAX) begin
                to_d = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end

        if (state_q == S_LOAD_EXP) begin
            exp_d = result;
        end
    end

    assign cmp_pass = (state_q == S_CMP) && !to_q && (got_q == exp_q);
    assign cmp_fail = (state_q == S_CMP) && (to_q || (got_q != exp_q));

    // clear has priority over any increment or capture in the same cycle.
    always_comb begin
        pass_d     = pass_q;
        fail_d     = fail_q;
        tocnt_d    = tocnt_q;
        error_d    = error_q;
        fail_got_d = fail_got_q;
        fail_exp_d = fail_exp_q;

        if (clear) begin
            pass_d     = '0;
            fail_d     = '0;
            tocnt_d    = '0;
            error_d    = 1'b0;
            fail_got_d = '0;
            fail_exp_d = '0;
        end else begin
            if (cmp_pass) begin
                pass_d = sat_inc(pass_q);
            end
            if (cmp_fail) begin
                fail_d  = sat_inc(fail_q);
                error_d = 1'b1;
                if (to_q) begin
                    tocnt_d = sat_inc(tocnt_q);
                end
                // Only the first fail since the last clear/reset is kept.
                if (!error_q) begin
                    fail_got_d = to_q ? '0 : got_q;
                    fail_exp_d = exp_q;
                end
            end
        end
    end

    assign dut_din     = din_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign timeout_cnt = tocnt_q;
    assign error       = error_q;
    assign fail_got    = fail_got_q;
    assign fail_exp    = fail_exp_q;

endmodule

// File: tb/tb_aes_result_checker.sv
module tb_aes_result_checker;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             work;
    logic             clear;
    logic             data_empty;
    logic             data_require;
    logic [127:0]     data = '0;
    logic             result_empty;
    logic             result_require;
    logic [127:0]     result = '0;
    logic [127:0]     dut_din;
    logic             dut_start;
    logic [127:0]     dut_dout = '0;
    logic             dut_done = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic             error;
    logic [127:0]     fail_got;
    logic [127:0]     fail_exp;

    aes_result_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .work(work), .clear(clear),
        .data_empty(data_empty), .data_require(data_require), .data(data),
        .result_empty(result_empty), .result_require(result_require), .result(result),
        .dut_din(dut_din), .dut_start(dut_start), .dut_dout(dut_dout), .dut_done(dut_done),
        .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
        .error(error), .fail_got(fail_got), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    // FIFO / chip storage: written by the stimulus, read by the responders.
    logic [127:0] dmem [0:63];
    logic [127:0] cmem [0:63];
    int           lmem [0:63];
    logic [127:0] rmem [0:63];
    int d_wr = 0, d_rd = 0, r_wr = 0, r_rd = 0, c_rd = 0;
    int           cur_lat;
    logic [127:0] cur_out;

    assign data_empty   = (d_rd == d_wr);
    assign result_empty = (r_rd == r_wr);

    // Data FIFO: output valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (data_require) begin
            #1;
            data = dmem[d_rd];
            d_rd = d_rd + 1;
        end
    end

    // Result FIFO.
    always @(posedge clk) begin
        if (result_require) begin
            #1;
            result = rmem[r_rd];
            r_rd = r_rd + 1;
        end
    end

    // Chip model: answers lat cycles after dut_start; lat 0 means silent.
    always @(posedge clk) begin
        if (dut_start) begin
            cur_lat = lmem[c_rd];
            cur_out = cmem[c_rd];
            c_rd = c_rd + 1;
            if (cur_lat > 0) begin
                repeat (cur_lat - 1) @(posedge clk);
                #1;
                dut_dout = cur_out;
                dut_done = 1'b1;
                @(posedge clk);
                #1;
                dut_done = 1'b0;
            end
        end
    end

    // Reference model state.
    int           checks = 0, failures = 0;
    int           m_pass = 0, m_fail = 0, m_to = 0;
    logic         m_err = 1'b0;
    logic [127:0] m_fgot = '0, m_fexp = '0;

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outcome of one transaction from its inputs alone.
    task automatic model_txn(input logic [127:0] got, input logic [127:0] gold, input int lat);
        bit to, bad;
        to  = (lat == 0) || (lat > TIMEOUT + 1);
        bad = to || (got != gold);
        if (to) m_to = sat(m_to);
        if (bad) m_fail = sat(m_fail);
        else     m_pass = sat(m_pass);
        if (bad && !m_err) begin
            m_err  = 1'b1;
            m_fgot = to ? 128'd0 : got;
            m_fexp = gold;
        end
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_to = 0; m_err = 1'b0; m_fgot = '0; m_fexp = '0;
    endtask

    task automatic push_res(input logic [127:0] gold);
        rmem[r_wr] = gold;
        r_wr = r_wr + 1;
    endtask

    task automatic push_txn(input logic [127:0] din, input logic [127:0] gold,
                            input logic [127:0] got, input int lat, input bit with_res);
        dmem[d_wr] = din;
        cmem[d_wr] = got;
        lmem[d_wr] = lat;
        if (with_res) push_res(gold);
        d_wr = d_wr + 1;
        model_txn(got, gold, lat);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pass"},    128'(pass_cnt),    128'(m_pass));
        chk({tag, "_fail"},    128'(fail_cnt),    128'(m_fail));
        chk({tag, "_timeout"}, 128'(timeout_cnt), 128'(m_to));
        chk({tag, "_error"},   128'(error),       128'(m_err));
        chk({tag, "_fail_got"}, fail_got, m_fgot);
        chk({tag, "_fail_exp"}, fail_exp, m_fexp);
    endtask

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return data_require;
            1:       return result_require;
            default: return dut_start;
        endcase
    endfunction

    task automatic wait_sig(input int s, input int budget, input string tag);
        int n = 0;
        while (!sel_sig(s) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < budget), 128'(1));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || data_require || (d_rd != d_wr)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < budget), 128'(1));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] g, d;
        int n, hits, base, kind, lat;

        rst_n = 1'b0; work = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      128'(busy),           128'(0));
        chk("rst_dreq",      128'(data_require),   128'(0));
        chk("rst_rreq",      128'(result_require), 128'(0));
        chk("rst_start",     128'(dut_start),      128'(0));
        chk("rst_din",       dut_din,              128'(0));
        check_model("rst");
        rst_n = 1'b1;
        @(negedge clk);
        work = 1'b1;

        // Single match with the standard AES-128 vector; start is two cycles after the pop.
        push_txn(PT0, CT0, CT0, 3, 1'b1);
        #1;
        wait_sig(0, 20, "match_dreq_wait");
        @(negedge clk);
        chk("match_dreq_pulse", 128'(data_require), 128'(0));
        chk("match_start_t1",   128'(dut_start),    128'(0));
        @(negedge clk);
        chk("match_start_t2",   128'(dut_start),    128'(1));
        chk("match_din",        dut_din,            PT0);
        wait_idle(60, "match_idle");
        check_model("match");
        chk("match_rpop", 128'(r_rd), 128'(r_wr));

        // Mismatch on bit 0, then a second mismatch must not move the capture.
        push_txn(rand128(), CT0, CT0 ^ 128'd1, 3, 1'b1);
        wait_idle(60, "mis1_idle");
        check_model("mis1");
        chk("mis1_fail_got_const", fail_got, CT0 ^ 128'd1);
        g = rand128();
        push_txn(rand128(), g, g ^ (128'd1 << $urandom_range(0, 127)), 4, 1'b1);
        wait_idle(60, "mis2_idle");
        check_model("mis2");

        do_clear();
        check_model("clear1");

        // Silent chip: WAIT spans TIMEOUT+1 cycles, one golden entry still consumed.
        push_txn(rand128(), rand128(), rand128(), 0, 1'b1);
        wait_sig(2, 20, "to_start_wait");
        n = 0;
        while (!result_require && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_start_to_rreq", 128'(n), 128'(TIMEOUT + 2));
        wait_idle(60, "to_idle");
        check_model("to");
        chk("to_rpop", 128'(r_rd), 128'(r_wr));

        do_clear();

        // Golden arrives late: FSM must sit in EXPECT without popping.
        g = rand128();
        push_txn(rand128(), g, g, 2, 1'b0);
        wait_sig(2, 20, "late_start_wait");
        hits = 0;
        repeat (25) begin
            @(negedge clk);
            if (result_require) hits++;
        end
        chk("late_no_rreq", 128'(hits), 128'(0));
        chk("late_busy",    128'(busy), 128'(1));
        push_res(g);
        wait_idle(60, "late_idle");
        check_model("late");

        // Four queued blocks; work drops during the second.
        base = d_rd;
        for (int i = 0; i < 4; i++) begin
            g = rand128();
            push_txn(rand128(), g, g, $urandom_range(1, 4), 1'b1);
        end
        n = 0;
        while (d_rd != base + 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_pop_wait", 128'(n < 60), 128'(1));
        work = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_drain_wait", 128'(n < 60), 128'(1));
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_require) hits++;
        end
        chk("bp_no_third_pop", 128'(hits),     128'(0));
        chk("bp_pops_held",    128'(d_rd),     128'(base + 2));
        chk("bp_mid_pass",     128'(pass_cnt), 128'(m_pass - 2));
        work = 1'b1;
        wait_idle(200, "bp_idle");
        check_model("bp");

        // Random mix including the accept/timeout latency boundary.
        do_clear();
        push_txn(rand128(), CT0, CT0, TIMEOUT + 1, 1'b1);
        push_txn(rand128(), CT0, CT0, TIMEOUT + 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            g = rand128();
            kind = $urandom_range(0, 2);
            lat  = (kind == 2) ? 0 : $urandom_range(1, 8);
            d    = (kind == 1) ? (g ^ (128'd1 << $urandom_range(0, 127))) : g;
            push_txn(rand128(), g, d, lat, 1'b1);
        end
        wait_idle(600, "rnd_idle");
        check_model("rnd");

        // Saturation: 17 passes on a 4-bit counter.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            g = rand128();
            push_txn(rand128(), g, g, $urandom_range(1, 6), 1'b1);
        end
        wait_idle(800, "sat_idle");
        check_model("sat");

        // clear in the CMP cycle beats the increment.
        g = rand128();
        push_txn(rand128(), g, g, 2, 1'b1);
        wait_sig(1, 40, "cmpclr_rreq_wait");
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        check_model("cmpclr");
        chk("cmpclr_busy", 128'(busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_result_checker.md
# aes_result_checker

Downstream consumer of the data generator in the AES verification platform. Pops plaintext/ciphertext blocks from the generator's data FIFO and drives each to the AES chip under test. Captures the chip's output, pops the matching golden block from the generator's result FIFO, compares the two, and keeps pass/fail/timeout statistics plus the first mismatching pair.

## Interface
- `TIMEOUT`, default 1023: maximum cycles to wait for `dut_done` after `dut_start`.
- `CNT_W`, default 16: width of each statistics counter.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `work`  in  1  — enable; a new transaction starts only while high.
- `clear`  in  1  — synchronous clear of counters, `error` and the mismatch capture.
- `data_empty`  in  1  — data FIFO empty.
- `data_require`  out  1  — data FIFO pop strobe, one cycle wide.
- `data`  in  128  — data FIFO output; valid the cycle after `data_require`.
- `result_empty`  in  1  — golden result FIFO empty.
- `result_require`  out  1  — result FIFO pop strobe, one cycle wide.
- `result`  in  128  — result FIFO output; valid the cycle after `result_require`.
- `dut_din`  out  128  — block presented to the chip; held stable until the next load.
- `dut_start`  out  1  — one-cycle start pulse to the chip.
- `dut_dout`  in  128  — chip output; valid in the cycle `dut_done` is high.
- `dut_done`  in  1  — chip completion pulse.
- `busy`  out  1  — high when the FSM is not in IDLE.
- `pass_cnt`  out  CNT_W  — number of matching blocks.
- `fail_cnt`  out  CNT_W  — mismatches plus timeouts.
- `timeout_cnt`  out  CNT_W  — number of timeouts.
- `error`  out  1  — sticky; set on the first fail.
- `fail_got`  out  128  — chip output of the first fail.
- `fail_exp`  out  128  — golden value of the first fail.

## Operation
- FSM states: IDLE, FETCH, DRIVE, WAIT, EXPECT, LOAD_EXP, CMP.
- IDLE: when `work & ~data_empty`, assert `data_require` for one cycle and go to FETCH.
- FETCH: latch `data` into `dut_din`, then go to DRIVE.
- DRIVE: pulse `dut_start`, clear the timer, clear the timeout flag, then go to WAIT.
- WAIT:
  - If `dut_done`: latch `dut_dout` into the got register and go to EXPECT.
  - Else if timer == `TIMEOUT`: set the timeout flag and go to EXPECT.
  - Otherwise increment the timer.
- EXPECT: wait for `~result_empty`, then assert `result_require` for one cycle and go to LOAD_EXP. A golden entry is always consumed, even on timeout, to keep both FIFOs aligned.
- LOAD_EXP: latch `result`, then go to CMP.
- CMP: resolve the transaction and return to IDLE.
  - Timeout flag set: `timeout_cnt`+1 and `fail_cnt`+1.
  - Else got == exp: `pass_cnt`+1.
  - Else: `fail_cnt`+1.
  - On any fail while `error`==0: set `error` and capture `fail_got`/`fail_exp`. For a timeout, `fail_got`=0.
- Counters saturate at all-ones and never wrap.
- `clear`:
  - Zeroes the counters, `error`, `fail_got` and `fail_exp`.
  - If `clear` and an increment occur in the same cycle, `clear` wins.
  - `clear` does not affect FSM state or `dut_din`.
- `work` low mid-transaction: the current transaction completes, then the FSM stays in IDLE.
- `dut_done` is ignored outside WAIT. A pulse in the DRIVE cycle is lost, so the chip must respond at least 1 cycle after `dut_start`.
- Reset values: all outputs 0 and FSM in IDLE. Reset mid-transaction abandons it; FIFO alignment is then the platform's responsibility (it resets together).

## Timing
- `data_require` (cycle t) → `data` captured at t+1 → `dut_start` at t+2.
- `dut_done` at cycle d → `result_require` at d+1 if the result FIFO is not empty → counter update at d+3 → IDLE at d+4.
- Minimum transaction: 7 cycles, from a `data_require` to the next `data_require`.
- Timeout fires when `dut_done` has not arrived by `TIMEOUT`+1 cycles after `dut_start`.
- At most one `data_require` and one `result_require` per transaction; the two never coincide.

## Test plan
- Single match: data 0x00112233…eeff, chip echoes golden 0x69c4e0d8…c55a after 3 cycles → `pass_cnt`=1, `fail_cnt`=0, `error`=0, `dut_start` 2 cycles after `data_require`.
- Mismatch: chip returns golden with bit 0 flipped → `fail_cnt`=1, `error`=1, `fail_exp`=golden, `fail_got`=golden^1. A second mismatch leaves the captures unchanged.
- Timeout with `TIMEOUT`=15 and chip silent → WAIT lasts 16 cycles, `timeout_cnt`=1, `fail_cnt`=1, one result entry popped, `fail_got`=0.
- Late golden: result FIFO empty for 20 cycles after `dut_done` → FSM holds in EXPECT with no `result_require`, then compares correctly.
- Backpressure and `work`: 4 back-to-back blocks, with `work` dropped during the 2nd → the 2nd completes, no 3rd pop until `work` returns, final `pass_cnt`=4.
- Saturation/clear: preload with `CNT_W`=4 and run 17 passes → `pass_cnt`=15. Assert `clear` in the CMP cycle → `pass_cnt`=0.
